// File: rtl/imem_sequencer_pkg.sv
// Shared types and constants for the instruction-memory sequencer.
package imem_sequencer_pkg;

  localparam int ADDR_W = 8;
  localparam int INSN_W = 15;
  localparam int DEPTH  = 1 << ADDR_W;

  // Defaults: three fill cycles for a four-stage processor, fill word is add r0 = r0 + 0.
  localparam int unsigned         DEF_DRAIN_CYCLES = 3;
  localparam logic [INSN_W-1:0]   DEF_NOP_INSN     = 15'h0000;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_STANDBY,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // True when pc addresses the final stored word; the length is one bit wider
  // than the pc so that a full 256-word program never wraps.
  function automatic logic is_last_addr(input logic [ADDR_W-1:0] pc,
                                        input logic [ADDR_W:0]   len);
    return ({1'b0, pc} == (len - (ADDR_W+1)'(1)));
  endfunction

endpackage

// File: rtl/imem_sequencer_if.sv
// Host-side load/control bus and processor-side instruction port.
interface imem_sequencer_if;
  import imem_sequencer_pkg::*;

  logic              load_start;
  logic              load_valid;
  logic              load_ready;
  logic [INSN_W-1:0] load_insn;
  logic              load_last;
  logic              run_start;
  logic              halt;
  logic [ADDR_W-1:0] address_imem;
  logic [INSN_W-1:0] q_imem;
  logic              proc_reset;
  logic              done;
  logic [ADDR_W:0]   prog_len;

  // Host / controller side.
  modport master (
    output load_start, load_valid, load_insn, load_last, run_start, halt,
    input  load_ready, address_imem, q_imem, proc_reset, done, prog_len
  );

  // Sequencer side.
  modport slave (
    input  load_start, load_valid, load_insn, load_last, run_start, halt,
    output load_ready, address_imem, q_imem, proc_reset, done, prog_len
  );

endinterface

// File: rtl/imem_store.sv
// Program storage: 256 x 15, synchronous write, asynchronous read so the
// instruction follows the program counter within the same cycle.
module imem_store
  import imem_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INSN_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INSN_W-1:0] rdata
);

  logic [INSN_W-1:0] mem [DEPTH];

  // Write port; contents are deliberately not cleared by any reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_sequencer.sv
// Loads a program into local storage, then replays it to a processor one word
// per cycle, followed by a NOP drain so the pipeline empties before done.
module imem_sequencer
  import imem_sequencer_pkg::*;
#(
  parameter int unsigned       DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter logic [INSN_W-1:0] NOP_INSN     = DEF_NOP_INSN
) (
  input logic             clock,
  input logic             reset,
  imem_sequencer_if.slave bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  // Counter preset on entry to DRAIN; DRAIN lasts until it has counted down through zero.
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic              load_ready_q, load_ready_d;
  logic              proc_reset_q, proc_reset_d;
  logic              done_q, done_d;
  logic              mem_we;
  logic [INSN_W-1:0] rd_data;

  imem_store u_store (
    .clock (clock),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (bus.load_insn),
    .raddr (pc_q),
    .rdata (rd_data)
  );

  // Next-state logic; load_start outranks halt, which outranks run_start.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    prog_len_d   = prog_len_q;
    pc_d         = pc_q;
    drain_cnt_d  = drain_cnt_q;
    proc_reset_d = proc_reset_q;
    done_d       = done_q;
    mem_we       = 1'b0;

    if (bus.load_start) begin
      state_d      = ST_LOAD;
      wptr_d       = '0;
      prog_len_d   = '0;
      pc_d         = '0;
      drain_cnt_d  = '0;
      proc_reset_d = 1'b1;
      done_d       = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.load_valid && load_ready_q) begin
            // The write is gated by reset so a word offered during reset is dropped.
            mem_we     = reset;
            wptr_d     = wptr_q + ADDR_W'(1);
            prog_len_d = prog_len_q + (ADDR_W+1)'(1);
            // Memory full ends the load even without load_last.
            if (bus.load_last || (wptr_q == '1)) begin
              state_d = ST_STANDBY;
            end
          end
        end
        ST_STANDBY, ST_DONE: begin
          if (bus.run_start) begin
            state_d      = ST_RUN;
            pc_d         = '0;
            proc_reset_d = 1'b0;
            done_d       = 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.halt) begin
            state_d      = ST_DONE;
            pc_d         = '0;
            proc_reset_d = 1'b1;
            done_d       = 1'b1;
          end else if (is_last_addr(pc_q, prog_len_q)) begin
            // pc is held on the last address while the pipeline drains.
            if (DRAIN_CYCLES == 0) begin
              state_d      = ST_DONE;
              pc_d         = '0;
              proc_reset_d = 1'b1;
              done_d       = 1'b1;
            end else begin
              state_d     = ST_DRAIN;
              drain_cnt_d = DRAIN_LOAD;
            end
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (bus.halt || (drain_cnt_q == '0)) begin
            state_d      = ST_DONE;
            pc_d         = '0;
            proc_reset_d = 1'b1;
            done_d       = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end

    load_ready_d = (state_d == ST_LOAD);
  end

  // Single state register; all control outputs are registered alongside the state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      wptr_q       <= '0;
      prog_len_q   <= '0;
      pc_q         <= '0;
      drain_cnt_q  <= '0;
      load_ready_q <= 1'b0;
      proc_reset_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      prog_len_q   <= prog_len_d;
      pc_q         <= pc_d;
      drain_cnt_q  <= drain_cnt_d;
      load_ready_q <= load_ready_d;
      proc_reset_q <= proc_reset_d;
      done_q       <= done_d;
    end
  end

  assign bus.load_ready   = load_ready_q;
  assign bus.address_imem = pc_q;
  assign bus.q_imem       = (state_q == ST_RUN) ? rd_data : NOP_INSN;
  assign bus.proc_reset   = proc_reset_q;
  assign bus.done         = done_q;
  assign bus.prog_len     = prog_len_q;

endmodule

// File: tb/tb_imem_sequencer.sv
// Bench for imem_sequencer: randomized loads and runs compared against a
// program-level model (stored words + length -> expected per-cycle trace).
module tb_imem_sequencer;
  import imem_sequencer_pkg::*;

  localparam int                DRAIN = 3;
  localparam logic [INSN_W-1:0] NOP   = 15'h0000;

  logic clock = 1'b0;
  logic reset;
  int   vec_count = 0;
  int   err_count = 0;

  // Model: the program as the host believes it was loaded.
  logic [INSN_W-1:0] model_mem [256];
  int                model_len = 0;

  imem_sequencer_if bus();

  imem_sequencer #(.DRAIN_CYCLES(DRAIN), .NOP_INSN(NOP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // {address, q, proc_reset, done, load_ready, prog_len}
  function automatic logic [34:0] pack(input logic [7:0] a, input logic [14:0] q,
                                       input logic pr, input logic dn, input logic rdy,
                                       input logic [8:0] len);
    return {a, q, pr, dn, rdy, len};
  endfunction

  function automatic logic [34:0] obs();
    return {bus.address_imem, bus.q_imem, bus.proc_reset, bus.done, bus.load_ready, bus.prog_len};
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) model_mem[i] = INSN_W'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vec_count++;
    if (obs() !== pack(8'd0, NOP, 1'b1, 1'b0, 1'b0, 9'd0)) begin
      err_count++;
      $display("FAIL reset_state: got %h want %h", obs(), pack(8'd0, NOP, 1'b1, 1'b0, 1'b0, 9'd0));
    end
    reset = 1'b1;
    @(negedge clock);
    vec_count++;
    if (obs() !== pack(8'd0, NOP, 1'b1, 1'b0, 1'b1, 9'd0)) begin
      err_count++;
      $display("FAIL reset_release: got %h want %h", obs(), pack(8'd0, NOP, 1'b1, 1'b0, 1'b1, 9'd0));
    end
    model_len = 0;
  endtask

  // Loads model_mem[0..n-1]; gap cycles carry junk data/last and stray run_start.
  task automatic load_prog(input string name, input int n, input bit use_last, input int gap_pct);
    int hs  = 0;
    int cyc = 0;
    @(negedge clock);
    bus.load_start = 1'b1;
    while (hs < n && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      bus.load_start = 1'b0;
      bus.run_start  = 1'b0;
      vec_count++;
      if (obs() !== pack(8'd0, NOP, 1'b1, 1'b0, 1'b1, 9'(hs))) begin
        err_count++;
        $display("FAIL %s load_cycle %0d: got %h want %h", name, cyc, obs(),
                 pack(8'd0, NOP, 1'b1, 1'b0, 1'b1, 9'(hs)));
      end
      if ($urandom_range(99) < gap_pct) begin
        bus.load_valid = 1'b0;
        bus.load_insn  = INSN_W'($urandom);
        bus.load_last  = 1'($urandom_range(1));
        bus.run_start  = ($urandom_range(3) == 0);
      end else begin
        bus.load_valid = 1'b1;
        bus.load_insn  = model_mem[hs];
        bus.load_last  = use_last && (hs == n - 1);
        hs++;
      end
    end
    @(negedge clock);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.run_start  = 1'b0;
    model_len = n;
    vec_count++;
    if (obs() !== pack(8'd0, NOP, 1'b1, 1'b0, 1'b0, 9'(n))) begin
      err_count++;
      $display("FAIL %s standby: got %h want %h", name, obs(), pack(8'd0, NOP, 1'b1, 1'b0, 1'b0, 9'(n)));
    end
  endtask

  // Pulses run_start and checks the trace up to index upto (inclusive).
  // Trace: words 0..len-1, then DRAIN cycles of NOP with the address held.
  task automatic run_steps(input string name, input int upto, input bit noise);
    logic [34:0] exp_v;
    @(negedge clock);
    bus.run_start = 1'b1;
    for (int k = 0; k <= upto; k++) begin
      @(negedge clock);
      bus.run_start  = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      if (k < model_len)
        exp_v = pack(8'(k), model_mem[k], 1'b0, 1'b0, 1'b0, 9'(model_len));
      else
        exp_v = pack(8'(model_len - 1), NOP, 1'b0, 1'b0, 1'b0, 9'(model_len));
      vec_count++;
      if (obs() !== exp_v) begin
        err_count++;
        $display("FAIL %s run_step %0d: got %h want %h", name, k, obs(), exp_v);
      end
      if (noise && k < upto) begin
        bus.load_valid = 1'($urandom_range(1));
        bus.load_insn  = INSN_W'($urandom);
        bus.load_last  = 1'($urandom_range(1));
        bus.run_start  = ($urandom_range(5) == 0);
      end
    end
  endtask

  task automatic test_run_full(input string name, input int halt_at, input bit noise);
    int total = model_len + DRAIN;
    int upto  = (halt_at >= 0) ? halt_at : total - 1;
    run_steps(name, upto, noise);
    if (halt_at >= 0) bus.halt = 1'b1;
    repeat (2) begin
      @(negedge clock);
      bus.halt = 1'b0;
      vec_count++;
      if (obs() !== pack(8'd0, NOP, 1'b1, 1'b1, 1'b0, 9'(model_len))) begin
        err_count++;
        $display("FAIL %s done_state: got %h want %h", name, obs(),
                 pack(8'd0, NOP, 1'b1, 1'b1, 1'b0, 9'(model_len)));
      end
    end
  endtask

  task automatic test_spec_vector();
    model_mem[0] = 15'h4105;
    model_mem[1] = 15'h0A03;
    model_mem[2] = 15'h1201;
    load_prog("spec3", 3, 1'b1, 0);
    test_run_full("spec3", -1, 1'b0);
  endtask

  task automatic test_full_256();
    fill_random(256);
    load_prog("full256", 256, 1'b0, 20);
    test_run_full("full256", -1, 1'b1);
  endtask

  task automatic test_halt();
    test_run_full("halt_at1", 1, 1'b0);
    test_run_full("rerun", -1, 1'b0);
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 5; it++) begin
      int n    = (it == 0) ? 1 : int'($urandom_range(2, 40));
      int pick = int'($urandom_range(0, n + DRAIN));
      fill_random(n);
      load_prog("gaps", n, 1'b1, 40);
      test_run_full("gaps", (pick == n + DRAIN) ? -1 : pick, 1'b1);
    end
  endtask

  task automatic test_priority();
    fill_random(6);
    load_prog("prio", 6, 1'b1, 0);
    run_steps("prio", 2, 1'b0);
    bus.load_start = 1'b1;
    bus.halt       = 1'b1;
    bus.run_start  = 1'b1;
    @(negedge clock);
    bus.load_start = 1'b0;
    bus.halt       = 1'b0;
    bus.run_start  = 1'b0;
    model_len = 0;
    vec_count++;
    if (obs() !== pack(8'd0, NOP, 1'b1, 1'b0, 1'b1, 9'd0)) begin
      err_count++;
      $display("FAIL priority: got %h want %h", obs(), pack(8'd0, NOP, 1'b1, 1'b0, 1'b1, 9'd0));
    end
  endtask

  task automatic test_reset_mid_run();
    logic [33:0] sub;
    fill_random(5);
    load_prog("rstrun", 5, 1'b1, 10);
    run_steps("rstrun", 1, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_len = 0;
    sub = {bus.address_imem, bus.q_imem, bus.proc_reset, bus.done, bus.prog_len};
    vec_count++;
    if (sub !== {8'd0, 15'h0000, 1'b1, 1'b0, 9'd0}) begin
      err_count++;
      $display("FAIL reset_mid_run: got %h want %h", sub, {8'd0, 15'h0000, 1'b1, 1'b0, 9'd0});
    end
    bus.run_start = 1'b1;
    repeat (3) begin
      @(negedge clock);
      bus.run_start = 1'b0;
      vec_count++;
      if (obs() !== pack(8'd0, NOP, 1'b1, 1'b0, 1'b1, 9'd0)) begin
        err_count++;
        $display("FAIL run_ignored_after_reset: got %h want %h", obs(), pack(8'd0, NOP, 1'b1, 1'b0, 1'b1, 9'd0));
      end
    end
  endtask

  initial begin
    reset          = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_insn  = '0;
    bus.load_last  = 1'b0;
    bus.run_start  = 1'b0;
    bus.halt       = 1'b0;
    test_reset();
    test_spec_vector();
    test_full_256();
    test_halt();
    test_random_gaps();
    test_priority();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_sequencer.md
IMEM_SEQUENCER -- requirements
Module: imem_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: cycles of NOP fill after the last instruction; equals processor pipeline depth minus 1.
REQ-002 SHALL have parameter NOP_INSN, default 15'h0000: fill word, i.e. add r0 = r0 + 0.
REQ-003 clock  in  1  single master clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 load_start  in  1  one-cycle pulse: clear program and enter LOAD.
REQ-006 load_valid  in  1  load word valid.
REQ-007 load_ready  out  1  sequencer accepts a load word.
REQ-008 load_insn  in  15  instruction word to store.
REQ-009 load_last  in  1  qualifies load_insn as the final program word.
REQ-010 run_start  in  1  one-cycle pulse: execute the stored program from address 0.
REQ-011 halt  in  1  abort execution immediately.
REQ-012 address_imem  out  8  program counter presented to the processor.
REQ-013 q_imem  out  15  instruction at address_imem, or fill word.
REQ-014 proc_reset  out  1  active-high reset to the processor.
REQ-015 done  out  1  program complete or halted.
REQ-016 prog_len  out  9  stored instruction count, 0..256.

Function
REQ-017 SHALL implement states LOAD, STANDBY, RUN, DRAIN and DONE.
REQ-018 LOAD: load_ready=1; on valid&ready, SHALL write mem[wptr]=load_insn, increment wptr and increment prog_len in the same edge.
REQ-019 LOAD: a handshake with load_last=1, or the 256th handshake, SHALL transition to STANDBY; load_ready SHALL drop in the cycle after that handshake.
REQ-020 load_valid outside LOAD SHALL be ignored, with load_ready=0.
REQ-021 run_start in STANDBY or DONE SHALL enter RUN next cycle with address_imem=0, proc_reset=0 and done=0 in that cycle; run_start in LOAD, RUN or DRAIN SHALL be ignored.
REQ-022 RUN: q_imem SHALL equal mem[address_imem] combinationally; address_imem SHALL increment by 1 per cycle.
REQ-023 RUN: the cycle after address_imem=prog_len-1 SHALL enter DRAIN with address_imem held.
REQ-024 With prog_len=256, the address SHALL NOT wrap to 0; DRAIN SHALL follow address 255.
REQ-025 DRAIN: q_imem=NOP_INSN for exactly DRAIN_CYCLES cycles, then DONE.
REQ-026 DONE: proc_reset=1, done=1, address_imem=0, q_imem=NOP_INSN; the program and prog_len SHALL be retained.
REQ-027 q_imem SHALL be NOP_INSN in every state other than RUN.
REQ-028 halt in RUN or DRAIN SHALL enter DONE on the next edge, skipping any remaining drain.
REQ-029 load_start in any state SHALL enter LOAD next cycle with wptr=0, prog_len=0, proc_reset=1 and done=0.
REQ-030 Priority on the same cycle: load_start > halt > run_start.

Reset
REQ-031 reset=0 sampled at a rising edge SHALL force: state LOAD, load_ready=0 during the reset cycle, wptr=0, prog_len=0, address_imem=0, q_imem=NOP_INSN, proc_reset=1, done=0.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset asserted mid-RUN SHALL assert proc_reset in the following cycle.

Structure
REQ-034 A shared package SHALL hold the state enum, ADDR_W=8, INSN_W=15, and the NOP_INSN and DRAIN_CYCLES defaults.
REQ-035 Storage SHALL be one sub-module, imem_store: 256x15, synchronous write, asynchronous read.
REQ-036 Control (FSM, wptr, PC, drain counter) SHALL reside in imem_sequencer.

Verification
REQ-037 Load 15'h4105, 15'h0A03, 15'h1201 with last on the 3rd, then run_start -> prog_len=3; addresses 0,1,2 carry those words; 3 NOP cycles follow; then done=1 and proc_reset=1.
REQ-038 Load 256 words with no load_last -> STANDBY after the 256th handshake, prog_len=256; run shows addresses 0..255 with no wrap, then DRAIN.
REQ-039 halt on the cycle address_imem=1 -> done=1 and proc_reset=1 on the next cycle; a following run_start restarts at address 0 with the same words.
REQ-040 load_start, halt and run_start asserted together in RUN -> LOAD, prog_len=0, load_ready=1.
REQ-041 reset=0 held for one cycle mid-RUN -> proc_reset=1 and q_imem=15'h0000 next cycle; run_start is ignored until a new load completes.
REQ-042 Toggle load_valid with gaps while load_ready=1 -> only valid&ready cycles are stored; prog_len equals the handshake count.
